// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC generator with boot sequencer, prioritised redirects and BTB prediction
module pc_gen #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_VEC   = '0,
    parameter int              BTB_ENTRIES = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            boot_up,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            jalr_valid,
    input  logic [XLEN-1:0] jalr_target,
    input  logic            stall,
    input  logic            btb_upd_valid,
    input  logic [XLEN-1:0] btb_upd_pc,
    input  logic [XLEN-1:0] btb_upd_target,
    input  logic            btb_upd_taken,
    output logic [XLEN-1:0] pc,
    output logic            pc_pred_taken,
    output logic            pc_running
);

    localparam int IW = $clog2(BTB_ENTRIES);
    localparam int TW = XLEN - IW - 2;
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TW-1:0]          tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0]        target_q [BTB_ENTRIES];
    logic [1:0]             ctr_q    [BTB_ENTRIES];

    logic            running;
    logic [IW-1:0]   rd_idx;
    logic [TW-1:0]   rd_tag;
    logic            rd_hit;
    logic            pred_taken;

    logic [IW-1:0]   wr_idx;
    logic [TW-1:0]   wr_tag;
    logic            wr_hit;
    logic            wr_en;
    logic [XLEN-1:0] target_d;
    logic [1:0]      ctr_d;

    assign running = (state_q == S_RUN);

    // Lookup is purely on the registered pc, so a write this cycle only shows up next cycle.
    assign rd_idx     = pc_q[IW+1:2];
    assign rd_tag     = pc_q[XLEN-1:IW+2];
    assign rd_hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign pred_taken = running && rd_hit && ctr_q[rd_idx][1];

    assign wr_idx = btb_upd_pc[IW+1:2];
    assign wr_tag = btb_upd_pc[XLEN-1:IW+2];
    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    assign wr_en  = running && btb_upd_valid && (btb_upd_taken || wr_hit);

    always_comb begin
        target_d = target_q[wr_idx];
        ctr_d    = ctr_q[wr_idx];
        if (btb_upd_taken) begin
            target_d = btb_upd_target;
            if (!wr_hit) begin
                ctr_d = 2'b10;
            end else if (ctr_q[wr_idx] != 2'b11) begin
                ctr_d = ctr_q[wr_idx] + 2'd1;
            end
        end else if (ctr_q[wr_idx] != 2'b00) begin
            ctr_d = ctr_q[wr_idx] - 2'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = RESET_VEC;
        case (state_q)
            S_IDLE: if (boot_up) state_d = S_LOAD;
            S_LOAD: if (!boot_up) state_d = S_RUN;
            S_RUN: begin
                if (trap_valid) begin
                    pc_d = trap_vec;
                end else if (redirect_valid) begin
                    pc_d = redirect_pc;
                end else if (jalr_valid) begin
                    pc_d = jalr_target;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (pred_taken) begin
                    pc_d = target_q[rd_idx];
                end else begin
                    pc_d = pc_q + XLEN'(4);
                end
                pc_d = pc_d & ALIGN_MASK;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_VEC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag, target and counter need no reset: they are qualified by valid_q.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= target_d;
            ctr_q[wr_idx]    <= ctr_d;
        end
    end

    assign pc            = pc_q;
    assign pc_pred_taken = pred_taken;
    assign pc_running    = running;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - scoreboard bench for pc_gen
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        boot_up;
    logic        trap_valid;
    logic [31:0] trap_vec;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        jalr_valid;
    logic [31:0] jalr_target;
    logic        stall;
    logic        btb_upd_valid;
    logic [31:0] btb_upd_pc;
    logic [31:0] btb_upd_target;
    logic        btb_upd_taken;
    logic [31:0] pc;
    logic        pc_pred_taken;
    logic        pc_running;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        pred;
        logic        run;
    } exp_t;

    exp_t sb[$];

    pc_gen #(
        .XLEN        (32),
        .RESET_VEC   (32'h0),
        .BTB_ENTRIES (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .boot_up        (boot_up),
        .trap_valid     (trap_valid),
        .trap_vec       (trap_vec),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .jalr_valid     (jalr_valid),
        .jalr_target    (jalr_target),
        .stall          (stall),
        .btb_upd_valid  (btb_upd_valid),
        .btb_upd_pc     (btb_upd_pc),
        .btb_upd_target (btb_upd_target),
        .btb_upd_taken  (btb_upd_taken),
        .pc             (pc),
        .pc_pred_taken  (pc_pred_taken),
        .pc_running     (pc_running)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic expect_after(input string tag, input logic [31:0] p, input logic pr, input logic r);
        exp_t e;
        e.tag  = tag;
        e.pc   = p;
        e.pred = pr;
        e.run  = r;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, ".pc"},   pc,                    e.pc);
            check({e.tag, ".pred"}, {31'd0, pc_pred_taken}, {31'd0, e.pred});
            check({e.tag, ".run"},  {31'd0, pc_running},    {31'd0, e.run});
        end
    endtask

    task automatic upd(input logic v, input logic [31:0] a, input logic [31:0] t, input logic tk);
        btb_upd_valid  = v;
        btb_upd_pc     = a;
        btb_upd_target = t;
        btb_upd_taken  = tk;
    endtask

    initial begin
        rst_n = 1'b0; boot_up = 1'b0; stall = 1'b0;
        trap_valid = 1'b0; trap_vec = '0;
        redirect_valid = 1'b0; redirect_pc = '0;
        jalr_valid = 1'b0; jalr_target = '0;
        upd(1'b0, 32'h0, 32'h0, 1'b0);

        // Reset and boot
        tick();
        expect_after("reset", 32'h0, 1'b0, 1'b0); tick();
        rst_n = 1'b1; boot_up = 1'b1;
        expect_after("boot1", 32'h0, 1'b0, 1'b0); tick();
        expect_after("boot2", 32'h0, 1'b0, 1'b0); tick();
        expect_after("boot3", 32'h0, 1'b0, 1'b0); tick();
        boot_up = 1'b0;
        expect_after("run0", 32'h0, 1'b0, 1'b1); tick();
        expect_after("seq4", 32'h4, 1'b0, 1'b1); tick();
        expect_after("seq8", 32'h8, 1'b0, 1'b1); tick();
        expect_after("seqC", 32'hC, 1'b0, 1'b1); tick();

        // Redirect priority
        trap_valid = 1'b1; trap_vec = 32'h100;
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        jalr_valid = 1'b1; jalr_target = 32'h300;
        stall = 1'b1;
        expect_after("prio_trap", 32'h100, 1'b0, 1'b1); tick();
        trap_valid = 1'b0;
        expect_after("prio_redir", 32'h200, 1'b0, 1'b1); tick();
        redirect_valid = 1'b0;
        expect_after("prio_jalr", 32'h300, 1'b0, 1'b1); tick();
        jalr_valid = 1'b0;
        expect_after("prio_stall", 32'h300, 1'b0, 1'b1); tick();
        stall = 1'b0;

        // Alignment and wrap
        jalr_valid = 1'b1; jalr_target = 32'h103;
        expect_after("align", 32'h100, 1'b0, 1'b1); tick();
        jalr_valid = 1'b0;
        trap_valid = 1'b1; trap_vec = 32'hFFFF_FFFC;
        expect_after("to_top", 32'hFFFF_FFFC, 1'b0, 1'b1); tick();
        trap_valid = 1'b0;
        expect_after("wrap", 32'h0, 1'b0, 1'b1); tick();

        // BTB train and predict
        upd(1'b1, 32'h10, 32'h40, 1'b1);
        expect_after("train", 32'h4, 1'b0, 1'b1); tick();
        upd(1'b0, 32'h0, 32'h0, 1'b0);
        expect_after("walk8", 32'h8, 1'b0, 1'b1); tick();
        expect_after("walkC", 32'hC, 1'b0, 1'b1); tick();
        expect_after("hit10", 32'h10, 1'b1, 1'b1); tick();
        expect_after("pred_jump", 32'h40, 1'b0, 1'b1); tick();

        // Two not-taken updates, the second under stall
        upd(1'b1, 32'h10, 32'h0, 1'b0);
        expect_after("nt1", 32'h44, 1'b0, 1'b1); tick();
        stall = 1'b1;
        expect_after("nt2_stall", 32'h44, 1'b0, 1'b1); tick();
        stall = 1'b0;
        upd(1'b0, 32'h0, 32'h0, 1'b0);
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        expect_after("weak10", 32'h10, 1'b0, 1'b1); tick();
        redirect_valid = 1'b0;
        expect_after("fall14", 32'h14, 1'b0, 1'b1); tick();

        // Aliasing: 0x30 shares index 4 with 0x10
        upd(1'b1, 32'h10, 32'h40, 1'b1);
        expect_after("alias_a", 32'h18, 1'b0, 1'b1); tick();
        upd(1'b1, 32'h30, 32'h80, 1'b1);
        expect_after("alias_b", 32'h1C, 1'b0, 1'b1); tick();
        upd(1'b0, 32'h0, 32'h0, 1'b0);
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        expect_after("miss10", 32'h10, 1'b0, 1'b1); tick();
        redirect_pc = 32'h30;
        expect_after("hit30", 32'h30, 1'b1, 1'b1); tick();
        redirect_valid = 1'b0;
        expect_after("jump80", 32'h80, 1'b0, 1'b1); tick();

        // Saturation: four taken then one not-taken keeps prediction
        upd(1'b1, 32'h30, 32'h80, 1'b1);
        expect_after("sat1", 32'h84, 1'b0, 1'b1); tick();
        expect_after("sat2", 32'h88, 1'b0, 1'b1); tick();
        expect_after("sat3", 32'h8C, 1'b0, 1'b1); tick();
        expect_after("sat4", 32'h90, 1'b0, 1'b1); tick();
        upd(1'b1, 32'h30, 32'h80, 1'b0);
        expect_after("sat_nt", 32'h94, 1'b0, 1'b1); tick();
        upd(1'b0, 32'h0, 32'h0, 1'b0);
        redirect_valid = 1'b1; redirect_pc = 32'h30;
        expect_after("still_taken", 32'h30, 1'b1, 1'b1); tick();
        redirect_valid = 1'b0;

        // JALR overrides a taken prediction
        jalr_valid = 1'b1; jalr_target = 32'h200;
        expect_after("override", 32'h200, 1'b0, 1'b1); tick();
        jalr_valid = 1'b0;

        // Retrain 0x10 so reset has something to clear
        upd(1'b1, 32'h10, 32'h40, 1'b1);
        expect_after("retrain", 32'h204, 1'b0, 1'b1); tick();
        upd(1'b0, 32'h0, 32'h0, 1'b0);
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        expect_after("rehit10", 32'h10, 1'b1, 1'b1); tick();
        redirect_valid = 1'b0;

        // Mid-run reset, redirects ignored in IDLE, then re-boot
        rst_n = 1'b0;
        expect_after("mid_rst", 32'h0, 1'b0, 1'b0); tick();
        rst_n = 1'b1; trap_valid = 1'b1; trap_vec = 32'h100;
        expect_after("idle_hold", 32'h0, 1'b0, 1'b0); tick();
        trap_valid = 1'b0; boot_up = 1'b1;
        expect_after("reload", 32'h0, 1'b0, 1'b0); tick();
        boot_up = 1'b0;
        expect_after("rerun", 32'h0, 1'b0, 1'b1); tick();
        expect_after("re4", 32'h4, 1'b0, 1'b1); tick();
        expect_after("re8", 32'h8, 1'b0, 1'b1); tick();
        expect_after("reC", 32'hC, 1'b0, 1'b1); tick();
        expect_after("re10_miss", 32'h10, 1'b0, 1'b1); tick();
        expect_after("re14", 32'h14, 1'b0, 1'b1); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised next-generation program-counter unit for the RISC-V fetch stage. It adds a boot sequencer, a prioritised redirect network (trap, resolved branch, JALR, stall) and a small direct-mapped branch target buffer (BTB) with 2-bit counters for next-PC prediction. It drives the instruction-memory address and tags each fetched PC with its prediction, so later stages can detect mispredicts.

## Interface
- XLEN, 32, address/PC width (≥ 16)
- RESET_VEC, 0, PC value held during boot and after reset
- BTB_ENTRIES, 8, BTB depth; power of two, 2..64
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- boot_up  in  1  boot request from loader; high while instruction memory is being loaded
- trap_valid  in  1  trap/exception redirect (highest priority)
- trap_vec  in  XLEN  trap target
- redirect_valid  in  1  resolved branch/jump mispredict redirect from MEM
- redirect_pc  in  XLEN  correct target for redirect
- jalr_valid  in  1  JALR redirect from MEM
- jalr_target  in  XLEN  JALR ALU result
- stall  in  1  hold PC (hazard/keep)
- btb_upd_valid  in  1  BTB training strobe from MEM
- btb_upd_pc  in  XLEN  PC of the resolved branch
- btb_upd_target  in  XLEN  resolved target
- btb_upd_taken  in  1  resolved direction
- pc  out  XLEN  current fetch PC (registered)
- pc_pred_taken  out  1  BTB predicted taken for current pc (combinational from pc)
- pc_running  out  1  high in RUN state

## Operation
- FSM states: IDLE, LOAD, RUN. IDLE→LOAD when boot_up=1. LOAD→RUN when boot_up=0. RUN stays in RUN; only rst_n leaves it.
- In IDLE and LOAD: pc loads RESET_VEC every cycle. pc_pred_taken=0. Redirect, stall and BTB update inputs are ignored.
- In RUN, the next pc is selected by strict priority:
  - trap_vec
  - redirect_pc
  - jalr_target
  - pc (stall)
  - BTB target (predict hit and taken)
  - pc+4
- All selected targets have bits [1:0] forced to 0. pc+4 wraps modulo 2^XLEN.
- BTB index = pc[IW+1:2], where IW=log2(BTB_ENTRIES). Tag = pc[XLEN-1:IW+2].
- Each BTB entry holds: valid, tag, target (XLEN), ctr (2 bits).
- Hit = valid and tag match. Predict taken = hit and ctr[1].
- BTB update (RUN only, when btb_upd_valid), indexed and tagged by btb_upd_pc:
  - taken and miss: write tag and target, set valid=1, ctr=2'b10.
  - taken and hit: write target, ctr increments, saturating at 3.
  - not-taken and hit: ctr decrements, saturating at 0. An entry with ctr=0 stays valid.
  - not-taken and miss: no change.
- Stall in the same cycle as a BTB update: the update still occurs.

## Timing
- Reset values: state=IDLE, pc=RESET_VEC, pc_running=0, pc_pred_taken=0, all BTB valid=0. BTB tag, target and ctr contents are don't-care.
- rst_n asserted in any state, including mid-RUN: all reset values apply on the next clock edge.
- Next-pc select is combinational; pc updates at the clock edge, giving 1-cycle redirect latency.
- First RUN cycle pc = RESET_VEC. It advances on the following edge.
- BTB read is combinational on the current pc. A write becomes visible the cycle after the update edge. A same-cycle update does not affect the prediction for the same index.
- A trap, redirect or JALR in the same cycle as a BTB hit overrides the prediction.

## Test plan
- Boot: rst_n low 2 cycles, boot_up high 3 cycles then low. Required: pc=RESET_VEC through IDLE/LOAD, pc_running rises on the first cycle after boot_up falls, then pc sequences 0,4,8,C.
- Priority: in RUN assert trap_valid (vec 0x100), redirect_valid (0x200), jalr_valid (0x300) and stall together. Required: next pc=0x100. Drop the trap: 0x200. Drop redirect: 0x300. Drop jalr: pc holds.
- Alignment and wrap: jalr_target=0x103 → pc=0x100. With pc=0xFFFFFFFC and no redirect → pc=0x0.
- BTB train: update pc=0x10, target=0x40, taken. Later, when pc reaches 0x10: pc_pred_taken=1 and next pc=0x40. Two not-taken updates (ctr 2→1→0): pc_pred_taken=0 and next pc=0x14.
- Aliasing and saturation (BTB_ENTRIES=8): train 0x10 taken, then update 0x30 (same index, different tag) taken. Required: 0x10 now misses, 0x30 hits. Four taken updates to 0x30 then one not-taken: prediction stays taken (ctr 3→2).
- Reset mid-run: after BTB training, pulse rst_n low 1 cycle. Required: state IDLE, pc=RESET_VEC, and after re-boot no BTB hit at 0x10.
